// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 requester.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_state_e;

  typedef logic [2:0] apb4_prot_t;

  localparam apb4_prot_t PROT_PRIVILEGED  = 3'b001;
  localparam apb4_prot_t PROT_NONSECURE   = 3'b010;
  localparam apb4_prot_t PROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb4_master.sv
// Single-outstanding APB4 requester: cmd stream in, SETUP/ACCESS on the bus, rsp stream out.
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb4_master
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb4_state_e state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  apb4_prot_t              pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    tout_q, tout_d;

  logic accept;
  logic timeout_hit;

  assign accept      = (state_q == IDLE) && cmd_valid;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is held low while rst is asserted so reset shows an all-zero interface.
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready = ~rst;
      SETUP:   psel = 1'b1;
      ACCESS:  begin psel = 1'b1; penable = 1'b1; end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tout_d   = tout_q;
    if (accept) begin
      cnt_d    = '0;
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
      pstrb_d  = cmd_write ? cmd_strb : '0;
      pprot_d  = cmd_prot;
    end
    if (state_q == ACCESS) begin
      cnt_d = cnt_q + 1'b1;
      // pready takes priority over a timeout reached in the same cycle
      if (pready) begin
        rdata_d = pwrite_q ? '0 : prdata;
        err_d   = pslverr;
        tout_d  = 1'b0;
      end else if (timeout_hit) begin
        rdata_d = '0;
        err_d   = 1'b1;
        tout_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tout_q;

endmodule
